// File: rtl/replay_writer.sv
`timescale 1ns/1ps
// Purpose: replays a swept register window from a golden source RF into a target RF, one write per distinct address.
// Latency: replay_addr_i sampled at cycle N -> dst_we_o at N+2 (one cycle for the source read, one for the write register).
// Backpressure: none; the controller paces the sweep, repeated/held addresses are dropped, an early drop of fetch_block_i flags incomplete_o.
module replay_writer #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int SKIP_ZERO  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_block_i,
    input  logic [ADDR_WIDTH-1:0] replay_addr_i,
    output logic [ADDR_WIDTH-1:0] src_raddr_o,
    input  logic [DATA_WIDTH-1:0] src_rdata_i,
    output logic                  dst_we_o,
    output logic [ADDR_WIDTH-1:0] dst_waddr_o,
    output logic [DATA_WIDTH-1:0] dst_wdata_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  incomplete_o
);

    localparam int NUM_REG = 2**ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REPLAY = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_nxt;

    logic                    valid_s1;
    logic [ADDR_WIDTH-1:0]   addr_s1;
    logic                    first;
    logic [ADDR_WIDTH-1:0]   last_addr;
    logic [NUM_REG-1:0]      bitmap;
    logic [NUM_REG-1:0]      req_mask;
    logic                    bitmap_full;
    logic                    pend;
    logic                    armed;
    logic                    zero_blocked;
    logic                    issue;
    logic                    start;
    logic                    pipe_empty;

    // Completion mask: address 0 is excluded when it is never written.
    always_comb begin
        req_mask = '1;
        if (SKIP_ZERO != 0) begin
            req_mask[0] = 1'b0;
        end
    end

    assign bitmap_full  = ((bitmap & req_mask) == req_mask);
    assign zero_blocked = (SKIP_ZERO != 0) && (replay_addr_i == '0);
    // A read issues only on a fresh address; holding or repeating an address never duplicates a write.
    assign issue        = (state == REPLAY) && fetch_block_i && !bitmap_full &&
                          (first || (replay_addr_i != last_addr)) && !zero_blocked;
    // armed blocks a fetch that was already high across reset release; pend keeps a request seen in DONE.
    assign start        = (state == IDLE) && ((fetch_block_i && armed) || pend);
    assign pipe_empty   = !valid_s1 && !dst_we_o;

    assign src_raddr_o  = (state == REPLAY) ? replay_addr_i : '0;
    assign busy_o       = (state == REPLAY) || (state == DRAIN) || valid_s1 || dst_we_o;
    assign done_o       = (state == DONE);

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = REPLAY;
            REPLAY:  if (!fetch_block_i || bitmap_full) state_nxt = DRAIN;
            DRAIN:   if (pipe_empty) state_nxt = bitmap_full ? DONE : IDLE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Replay bookkeeping: start qualification, address-change tracking and the sticky abort flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed        <= 1'b0;
            pend         <= 1'b0;
            first        <= 1'b0;
            last_addr    <= '0;
            incomplete_o <= 1'b0;
        end else begin
            if (!fetch_block_i) begin
                armed <= 1'b1;
            end
            if (state == DONE) begin
                pend <= fetch_block_i;
            end else if (state == IDLE) begin
                pend <= 1'b0;
            end
            if (start) begin
                first     <= 1'b1;
                last_addr <= '0;
            end else if (state == REPLAY) begin
                first <= 1'b0;
                if (fetch_block_i) begin
                    last_addr <= replay_addr_i;
                end
            end
            // Leaving DRAIN decides the flag: set on an aborted window, cleared by a completed one.
            if ((state == DRAIN) && pipe_empty) begin
                incomplete_o <= !bitmap_full;
            end
        end
    end

    // Written-address bitmap, cleared at the start of every replay window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitmap <= '0;
        end else if (start) begin
            bitmap <= '0;
        end else if (dst_we_o) begin
            bitmap[dst_waddr_o] <= 1'b1;
        end
    end

    // Stage 1: remember which address was read from the source this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_s1 <= 1'b0;
            addr_s1  <= '0;
        end else begin
            valid_s1 <= issue;
            if (issue) begin
                addr_s1 <= replay_addr_i;
            end
        end
    end

    // Stage 2: register the target write once the source data has returned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dst_we_o    <= 1'b0;
            dst_waddr_o <= '0;
            dst_wdata_o <= '0;
        end else begin
            dst_we_o <= valid_s1;
            if (valid_s1) begin
                dst_waddr_o <= addr_s1;
                dst_wdata_o <= src_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_replay_writer.sv
`timescale 1ns/1ps
// Directed bench for replay_writer: one instance with SKIP_ZERO=1 and one with SKIP_ZERO=0,
// each fed by a synchronous-read source model returning addr*0x0101.
module tb_replay_writer;

    logic        clk;
    logic        rst_n;
    logic        fetch;
    logic        fetch_z;
    logic [4:0]  addr;

    logic [4:0]  src_raddr,  src_raddr_z;
    logic [31:0] src_rdata,  src_rdata_z;
    logic        dst_we,     dst_we_z;
    logic [4:0]  dst_waddr,  dst_waddr_z;
    logic [31:0] dst_wdata,  dst_wdata_z;
    logic        busy,       busy_z;
    logic        done,       done_z;
    logic        incomplete, incomplete_z;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic sel_z = 1'b0;

    int wr_cnt [32];
    int wr_cyc [32];
    int drv_cyc[32];
    int wr_total, data_err, done_cnt;
    int wr_total_z, wr0_z, data_err_z, done_cnt_z;

    replay_writer #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .SKIP_ZERO(1)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_block_i(fetch), .replay_addr_i(addr),
        .src_raddr_o(src_raddr), .src_rdata_i(src_rdata),
        .dst_we_o(dst_we), .dst_waddr_o(dst_waddr), .dst_wdata_o(dst_wdata),
        .busy_o(busy), .done_o(done), .incomplete_o(incomplete)
    );

    replay_writer #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .SKIP_ZERO(0)) dut_z (
        .clk(clk), .rst_n(rst_n), .fetch_block_i(fetch_z), .replay_addr_i(addr),
        .src_raddr_o(src_raddr_z), .src_rdata_i(src_rdata_z),
        .dst_we_o(dst_we_z), .dst_waddr_o(dst_waddr_z), .dst_wdata_o(dst_wdata_z),
        .busy_o(busy_z), .done_o(done_z), .incomplete_o(incomplete_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Golden source register files: synchronous read, data one cycle after the address.
    always @(posedge clk) begin
        src_rdata   <= 32'(src_raddr)   * 32'h0101;
        src_rdata_z <= 32'(src_raddr_z) * 32'h0101;
    end

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        return 32'(a) * 32'h0101;
    endfunction

    // Write/done monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (dst_we) begin
            wr_cnt[dst_waddr] = wr_cnt[dst_waddr] + 1;
            wr_cyc[dst_waddr] = cyc;
            wr_total = wr_total + 1;
            if (dst_wdata !== exp_data(dst_waddr)) data_err = data_err + 1;
        end
        if (done) done_cnt = done_cnt + 1;
        if (dst_we_z) begin
            wr_total_z = wr_total_z + 1;
            if (dst_waddr_z == 5'd0) wr0_z = wr0_z + 1;
            if (dst_wdata_z !== exp_data(dst_waddr_z)) data_err_z = data_err_z + 1;
        end
        if (done_z) done_cnt_z = done_cnt_z + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 32; i++) begin
            wr_cnt[i] = 0;
            wr_cyc[i] = 0;
            drv_cyc[i] = 0;
        end
        wr_total = 0; data_err = 0; done_cnt = 0;
        wr_total_z = 0; wr0_z = 0; data_err_z = 0; done_cnt_z = 0;
    endtask

    task automatic set_fetch(input logic v);
        fetch   = sel_z ? 1'b0 : v;
        fetch_z = sel_z ? v : 1'b0;
    endtask

    function automatic logic cur_busy();
        return sel_z ? busy_z : busy;
    endfunction

    // Raise fetch with address 0 until the selected DUT enters REPLAY, then sweep 0..last.
    task automatic sweep(input int last, input int hold, input bit drop);
        int n;
        set_fetch(1'b1);
        addr = 5'd0;
        n = 0;
        do begin
            step();
            n++;
        end while (!cur_busy() && n < 4);
        check("replay_start", 32'(cur_busy()), 32'd1);
        for (int a = 0; a <= last; a++) begin
            addr = 5'(a);
            drv_cyc[a] = cyc;
            step();
        end
        repeat (hold) step();
        if (drop) set_fetch(1'b0);
    endtask

    function automatic int count_not(input int k);
        int bad = 0;
        for (int i = 1; i < 32; i++) if (wr_cnt[i] != k) bad++;
        return bad;
    endfunction

    initial begin
        int n;
        rst_n = 1'b0; fetch = 1'b0; fetch_z = 1'b0; addr = 5'd0;
        clear_counts();
        repeat (3) step();
        check("rst_we",    32'(dst_we), 32'd0);
        check("rst_waddr", 32'(dst_waddr), 32'd0);
        check("rst_wdata", dst_wdata, 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_incomplete", 32'(incomplete), 32'd0);
        rst_n = 1'b1;
        repeat (2) step();

        // Full sweep with the last address held.
        clear_counts();
        sweep(31, 3, 1'b1);
        repeat (6) step();
        check("full_writes", 32'(wr_total), 32'd31);
        check("full_addr0", 32'(wr_cnt[0]), 32'd0);
        check("full_unique", 32'(count_not(1)), 32'd0);
        check("full_data", 32'(data_err), 32'd0);
        check("full_done", 32'(done_cnt), 32'd1);
        check("full_incomplete", 32'(incomplete), 32'd0);
        check("latency_addr5", 32'(wr_cyc[5] - drv_cyc[5]), 32'd2);
        check("full_busy_end", 32'(busy), 32'd0);

        // Abort after address 10.
        clear_counts();
        sweep(10, 0, 1'b1);
        repeat (4) step();
        check("abort_writes", 32'(wr_total), 32'd10);
        check("abort_addr10", 32'(wr_cnt[10]), 32'd1);
        check("abort_addr11", 32'(wr_cnt[11]), 32'd0);
        check("abort_done", 32'(done_cnt), 32'd0);
        check("abort_incomplete", 32'(incomplete), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        repeat (3) step();
        check("abort_sticky", 32'(incomplete), 32'd1);

        // Reset mid-replay while a write is in flight.
        clear_counts();
        sweep(6, 0, 1'b0);
        addr = 5'd7;
        check("pre_rst_we", 32'(dst_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_we", 32'(dst_we), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_incomplete", 32'(incomplete), 32'd0);
        set_fetch(1'b0);
        repeat (2) step();
        rst_n = 1'b1;
        clear_counts();
        repeat (3) step();
        check("post_rst_nowrite", 32'(wr_total), 32'd0);
        sweep(31, 3, 1'b1);
        repeat (6) step();
        check("post_rst_done", 32'(done_cnt), 32'd1);
        check("post_rst_incomplete", 32'(incomplete), 32'd0);
        check("post_rst_writes", 32'(wr_total), 32'd31);

        // Back-to-back: fetch kept high through DONE.
        clear_counts();
        sweep(31, 3, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 20);
        check("b2b_first_done", 32'(done), 32'd1);
        addr = 5'd0;
        sweep(31, 3, 1'b1);
        repeat (6) step();
        check("b2b_done", 32'(done_cnt), 32'd2);
        check("b2b_writes", 32'(wr_total), 32'd62);
        check("b2b_unique", 32'(count_not(2)), 32'd0);
        check("b2b_data", 32'(data_err), 32'd0);
        check("b2b_incomplete", 32'(incomplete), 32'd0);

        // SKIP_ZERO=0 instance: address 0 is written too.
        sel_z = 1'b1;
        clear_counts();
        sweep(31, 3, 1'b1);
        repeat (6) step();
        check("z_writes", 32'(wr_total_z), 32'd32);
        check("z_addr0", 32'(wr0_z), 32'd1);
        check("z_data", 32'(data_err_z), 32'd0);
        check("z_done", 32'(done_cnt_z), 32'd1);
        check("z_incomplete", 32'(incomplete_z), 32'd0);
        check("z_main_idle", 32'(wr_total), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
